// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single unified memory port between the instruction fetch unit (IFU)
//   and the load/store unit (LSU). Exactly one transaction is in flight at a time:
//   grant a requester, latch its request, issue it to memory, wait for the memory
//   response, then return the response to the requester that owns it.
//
// Configuration macro
//   MEM_ARB_RR_EN  defined  : round-robin tie break (the requester not granted last
//                             wins; IFU wins the first tie after reset)
//                  undefined: fixed priority, LSU always wins ties
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   ifu_req_valid_i/ready_o        IFU fetch request handshake
//   ifu_addr_i                     fetch address
//   ifu_resp_valid_o, ifu_rdata_o  one-cycle fetch response pulse and data
//   lsu_req_valid_i/ready_o        LSU request handshake
//   lsu_we_i, lsu_format_i         store enable, access size code
//   lsu_addr_i, lsu_wdata_i        load/store address, store data
//   lsu_resp_valid_o, lsu_rdata_o  one-cycle load/store response pulse and data
//   mem_req_valid_o/ready_i        request handshake towards memory
//   mem_we_o, mem_format_o,
//   mem_addr_o, mem_wdata_o        latched request fields
//   mem_resp_valid_i, mem_rdata_i  memory response
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid_i,
    output logic                  ifu_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
    output logic                  ifu_resp_valid_o,
    output logic [DATA_WIDTH-1:0] ifu_rdata_o,
    input  logic                  lsu_req_valid_i,
    output logic                  lsu_req_ready_o,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_format_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_resp_valid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_we_o,
    output logic [1:0]            mem_format_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_resp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;
    localparam logic [1:0] FMT_WORD = 2'b10;

    state_e                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic [1:0]              fmt_q, fmt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_WIDTH-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                    grant_ifu, grant_lsu;
    logic                    can_accept;

    // Grants are only offered in IDLE, and never while reset is held so that
    // both ready outputs read 0 during reset even if requesters are active.
    assign can_accept = rst_n && (state_q == IDLE);

`ifdef MEM_ARB_RR_EN
    logic last_lsu_q, last_lsu_d;

    // Round-robin tie break: on a tie the requester that did not win the most
    // recent grant goes first; a lone requester always wins.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (ifu_req_valid_i && lsu_req_valid_i) begin
            grant_ifu = last_lsu_q;
            grant_lsu = !last_lsu_q;
        end else begin
            grant_ifu = ifu_req_valid_i;
            grant_lsu = lsu_req_valid_i;
        end
    end

    // The pointer remembers who won the last accepted request.
    always_comb begin
        last_lsu_d = last_lsu_q;
        if (can_accept && (grant_ifu || grant_lsu)) begin
            last_lsu_d = grant_lsu;
        end
    end

    // Reset value pretends the LSU won last, so the IFU wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_lsu_q <= 1'b1;
        end else begin
            last_lsu_q <= last_lsu_d;
        end
    end
`else
    // Fixed priority: the LSU wins every tie.
    assign grant_lsu = lsu_req_valid_i;
    assign grant_ifu = ifu_req_valid_i && !lsu_req_valid_i;
`endif

    assign ifu_req_ready_o = can_accept && grant_ifu;
    assign lsu_req_ready_o = can_accept && grant_lsu;

    // Transaction sequencing: latch the winner's request, hold it on the memory
    // port until accepted, capture the response, then present it for one cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        fmt_d       = fmt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (ifu_req_ready_o) begin
                    owner_d = OWNER_IFU;
                    we_d    = 1'b0;
                    fmt_d   = FMT_WORD;
                    addr_d  = ifu_addr_i;
                    wdata_d = '0;
                    state_d = ISSUE;
                end else if (lsu_req_ready_o) begin
                    owner_d = OWNER_LSU;
                    we_d    = lsu_we_i;
                    fmt_d   = lsu_format_i;
                    addr_d  = lsu_addr_i;
                    wdata_d = lsu_wdata_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid_i) begin
                    if (owner_q == OWNER_IFU) begin
                        ifu_rdata_d = mem_rdata_i;
                    end else begin
                        lsu_rdata_d = we_q ? '0 : mem_rdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request/response registers; reset drops any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_IFU;
            we_q        <= 1'b0;
            fmt_q       <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            fmt_q       <= fmt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign mem_req_valid_o  = (state_q == ISSUE);
    assign mem_we_o         = we_q;
    assign mem_format_o     = fmt_q;
    assign mem_addr_o       = addr_q;
    assign mem_wdata_o      = wdata_q;
    assign ifu_resp_valid_o = (state_q == RESP) && (owner_q == OWNER_IFU);
    assign lsu_resp_valid_o = (state_q == RESP) && (owner_q == OWNER_LSU);
    assign ifu_rdata_o      = ifu_rdata_q;
    assign lsu_rdata_o      = lsu_rdata_q;

endmodule
